// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply sequencer for modular exponentiation.
// Drives one external modular multiplier through a load/ready handshake.
module modexp_sequencer #(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned EXP_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result,
  output logic [15:0]          mm_count,
  output logic                 mm_load,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_n,
  input  logic                 mm_ready,
  input  logic [WIDTH-1:0]     mm_result
);

  localparam int unsigned IW = $clog2(EXP_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE, CHECK, SCAN, SQ_LOAD, SQ_WAIT, MUL_LOAD, MUL_WAIT, FINISH
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0]     base_q, mod_q, r_q, result_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [IW-1:0]        idx_q;
  logic                 err_q, first_wait_q;

  logic accept, idx_dec, r_from_base, r_from_mm, check_en, cnt_inc;
  logic exp_bit, idx_zero, captured, bad_args;

  assign exp_bit  = exp_q[idx_q];
  assign idx_zero = (idx_q == '0);
  assign bad_args = (mod_q == '0) || (base_q >= mod_q);
  // The first WAIT cycle may still see ready from the previous multiply.
  assign captured = mm_ready && !first_wait_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    accept      = 1'b0;
    idx_dec     = 1'b0;
    r_from_base = 1'b0;
    r_from_mm   = 1'b0;
    check_en    = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = CHECK;
        end
      end
      CHECK: begin
        check_en   = 1'b1;
        next_state = (bad_args || exp_q == '0) ? FINISH : SCAN;
      end
      SCAN: begin
        if (exp_bit) begin
          r_from_base = 1'b1;
          if (idx_zero) next_state = FINISH;
          else begin
            idx_dec    = 1'b1;
            next_state = SQ_LOAD;
          end
        end else begin
          idx_dec = 1'b1;
        end
      end
      SQ_LOAD: begin
        cnt_inc    = 1'b1;
        next_state = SQ_WAIT;
      end
      SQ_WAIT: begin
        if (captured) begin
          r_from_mm = 1'b1;
          if (exp_bit)       next_state = MUL_LOAD;
          else if (idx_zero) next_state = FINISH;
          else begin
            idx_dec    = 1'b1;
            next_state = SQ_LOAD;
          end
        end
      end
      MUL_LOAD: begin
        cnt_inc    = 1'b1;
        next_state = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (captured) begin
          r_from_mm = 1'b1;
          if (idx_zero) next_state = FINISH;
          else begin
            idx_dec    = 1'b1;
            next_state = SQ_LOAD;
          end
        end
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q       <= '0;
      mod_q        <= '0;
      exp_q        <= '0;
      r_q          <= '0;
      result_q     <= '0;
      idx_q        <= '0;
      err_q        <= 1'b0;
      first_wait_q <= 1'b0;
      mm_count     <= '0;
    end else begin
      first_wait_q <= cnt_inc;
      if (accept) begin
        base_q   <= base;
        exp_q    <= exponent;
        mod_q    <= modulus;
        mm_count <= '0;
        idx_q    <= IW'(EXP_WIDTH - 1);
        err_q    <= 1'b0;
      end
      if (check_en) begin
        if (bad_args) begin
          r_q   <= '0;
          err_q <= 1'b1;
        end else if (exp_q == '0) begin
          r_q <= WIDTH'(mod_q != WIDTH'(1));
        end
      end
      if (idx_dec)     idx_q <= idx_q - IW'(1);
      if (r_from_base) r_q   <= base_q;
      if (r_from_mm)   r_q   <= mm_result;
      if (cnt_inc && mm_count != '1) mm_count <= mm_count + 16'd1;
      if (state == FINISH) result_q <= r_q;
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == FINISH);
  assign err     = err_q;
  // r_q is final during FINISH; result_q then holds it until the next job ends.
  assign result  = done ? r_q : result_q;
  assign mm_load = (state == SQ_LOAD) || (state == MUL_LOAD);
  assign mm_n    = mod_q;

  always_comb begin
    mm_a = '0;
    mm_b = '0;
    case (state)
      SQ_LOAD, SQ_WAIT: begin
        mm_a = r_q;
        mm_b = r_q;
      end
      MUL_LOAD, MUL_WAIT: begin
        mm_a = r_q;
        mm_b = base_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_modexp_sequencer.sv
// Self-checking bench for modexp_sequencer with a behavioural multiplier
// and a plain-arithmetic modular exponentiation reference.
module tb_modexp_sequencer;

  localparam int unsigned W = 32;
  localparam int unsigned E = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  base = '0;
  logic [E-1:0]  exponent = '0;
  logic [W-1:0]  modulus = '0;
  logic          busy, done, err, mm_load;
  logic [W-1:0]  result, mm_a, mm_b, mm_n;
  logic [15:0]   mm_count;
  logic          mm_ready = 1'b1;
  logic [W-1:0]  mm_result = 32'hDEADBEEF;

  modexp_sequencer #(.WIDTH(W), .EXP_WIDTH(E)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .exponent(exponent),
    .modulus(modulus), .busy(busy), .done(done), .err(err), .result(result),
    .mm_count(mm_count), .mm_load(mm_load), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
    .mm_ready(mm_ready), .mm_result(mm_result)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int last_accept = 0;

  // Multiplier model: keeps ready (stale) through the first wait cycle.
  logic [W-1:0] job_n = '0;
  bit           stall_first = 1'b0;
  int           loads = 0;
  int           loads_at_job = 0;
  int           op_bad = 0;
  bit           pending = 1'b0;
  bit           first = 1'b0;
  int           lat = 0;
  logic [W-1:0] op_a = '0, op_b = '0;

  always @(negedge clk) begin
    if (reset) begin
      pending = 1'b0;
    end else if (mm_load) begin
      if (pending) op_bad++;
      loads++;
      op_a = mm_a;
      op_b = mm_b;
      if (mm_n != job_n) op_bad++;
      lat = (stall_first && loads - loads_at_job == 1) ? 50 : int'($urandom_range(1, 4));
      pending = 1'b1;
      first = 1'b1;
    end else if (pending) begin
      if (mm_a != op_a || mm_b != op_b) op_bad++;
      if (first) first = 1'b0;
      else if (lat == 0) begin
        mm_ready  = 1'b1;
        mm_result = W'((64'(op_a) * 64'(op_b)) % 64'(job_n));
        pending   = 1'b0;
      end else begin
        mm_ready  = 1'b0;
        mm_result = $urandom;
        lat--;
      end
    end
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void ref_model(input longint unsigned b, input longint unsigned e,
                                    input longint unsigned n, output longint unsigned r,
                                    output bit er, output int cnt);
    longint unsigned x;
    int k, w;
    if (n == 0 || b >= n) begin
      r = 0; er = 1'b1; cnt = 0;
      return;
    end
    er = 1'b0;
    if (e == 0) begin
      r = (n == 1) ? 0 : 1; cnt = 0;
      return;
    end
    r = 1; x = b; k = 0; w = 0;
    for (int i = 0; i < int'(E); i++) begin
      if (((e >> i) & 1) == 1) begin
        r = (r * x) % n;
        k = i + 1;
        w++;
      end
      x = (x * x) % n;
    end
    cnt = (k - 1) + (w - 1);
  endfunction

  task automatic run_job(input string name, input logic [W-1:0] b, input logic [E-1:0] e,
                         input logic [W-1:0] n, input logic [W-1:0] exp_r, input bit exp_err,
                         input int exp_cnt, input bit poke, input bit settle);
    int waits, cyc, l0, b0;
    job_n = n;
    loads_at_job = loads;
    l0 = loads;
    b0 = op_bad;
    base = b; exponent = e; modulus = n; start = 1'b1;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!busy && waits < 10);
    start = 1'b0;
    last_accept = waits;
    if (!busy) begin
      chk({name, ".accept"}, 0, 1);
      return;
    end
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 3) begin
        base = 32'd5; exponent = 16'd3; modulus = 32'd7; start = 1'b1;
      end else if (poke && cyc == 4) begin
        start = 1'b0;
      end
    end
    chk({name, ".done"}, done, 1);
    if (!done) return;
    chk({name, ".result"}, result, exp_r);
    chk({name, ".err"}, err, exp_err);
    chk({name, ".mm_count"}, mm_count, exp_cnt);
    chk({name, ".loads"}, loads - l0, exp_cnt);
    chk({name, ".op_stable"}, op_bad - b0, 0);
    if (settle) begin
      @(negedge clk);
      chk({name, ".done_pulse"}, {done, busy}, 0);
      chk({name, ".result_hold"}, result, exp_r);
    end
  endtask

  typedef struct {
    logic [W-1:0] b;
    logic [E-1:0] e;
    logic [W-1:0] n;
    logic [W-1:0] r;
    bit           er;
    int           cnt;
  } vec_t;

  vec_t tbl[6];

  initial begin
    longint unsigned rr;
    bit re;
    int rc, dones, waits;
    logic [W-1:0] rb, rn;
    logic [E-1:0] rexp;

    tbl[0] = '{b: 4,   e: 13, n: 497, r: 445, er: 0, cnt: 5};
    tbl[1] = '{b: 5,   e: 0,  n: 497, r: 1,   er: 0, cnt: 0};
    tbl[2] = '{b: 0,   e: 0,  n: 1,   r: 0,   er: 0, cnt: 0};
    tbl[3] = '{b: 498, e: 5,  n: 497, r: 0,   er: 1, cnt: 0};
    tbl[4] = '{b: 3,   e: 5,  n: 0,   r: 0,   er: 1, cnt: 0};
    tbl[5] = '{b: 7,   e: 1,  n: 11,  r: 7,   er: 0, cnt: 0};

    repeat (3) @(negedge clk);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.result", result, 0);
    chk("reset.mm_count", mm_count, 0);
    chk("reset.mm_load", mm_load, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_job($sformatf("tbl%0d", i), tbl[i].b, tbl[i].e, tbl[i].n, tbl[i].r,
              tbl[i].er, tbl[i].cnt, 1'b0, 1'b1);
    chk("accept_latency", last_accept, 1);

    // Long stall on the first square.
    stall_first = 1'b1;
    run_job("stall", 4, 13, 497, 445, 1'b0, 5, 1'b0, 1'b1);
    stall_first = 1'b0;

    // Start pulsed while busy must be ignored.
    ref_model(3, 200, 1000003, rr, re, rc);
    run_job("poke", 3, 200, 1000003, W'(rr), re, rc, 1'b1, 1'b1);

    // Back-to-back: start offered in the done cycle, accepted the cycle after.
    run_job("b2b_a", 7, 1, 11, 7, 1'b0, 0, 1'b0, 1'b0);
    run_job("b2b_b", 4, 13, 497, 445, 1'b0, 5, 1'b0, 1'b1);
    chk("b2b.accept_latency", last_accept, 2);

    // Reset while stalled in the square wait.
    stall_first = 1'b1;
    job_n = 497;
    loads_at_job = loads;
    base = 4; exponent = 13; modulus = 497; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waits = 0;
    while (!(loads > loads_at_job && !mm_load) && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    chk("rst.reached_wait", (loads > loads_at_job) && busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.result", result, 0);
    chk("rst.mm_count", mm_count, 0);
    chk("rst.mm_ops", {mm_load, mm_a, mm_b, mm_n}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    stall_first = 1'b0;
    dones = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("rst.no_done", dones, 0);
    ref_model(3, 200, 1000003, rr, re, rc);
    run_job("after_rst", 3, 200, 1000003, W'(rr), re, rc, 1'b0, 1'b1);

    // Randomised jobs against the reference.
    for (int j = 0; j < 30; j++) begin
      case ($urandom_range(0, 9))
        0:       rn = '0;
        1, 2, 3: rn = W'($urandom_range(1, 1000));
        default: rn = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) rb = rn + W'($urandom_range(0, 3));
      else if (rn != '0)             rb = $urandom % rn;
      else                           rb = $urandom;
      rexp = ($urandom_range(0, 9) == 0) ? '0 : E'($urandom);
      ref_model(rb, rexp, rn, rr, re, rc);
      run_job($sformatf("rand%0d", j), rb, rexp, rn, W'(rr), re, rc, 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
